// File: rtl/prefetch_unit_if.sv
// prefetch_unit_if: instruction-memory fetch port and ID-stage delivery port of the prefetch unit
interface prefetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
);
  logic                    imem_req_o;
  logic [ADDR_W-1:0]       imem_addr_o;
  logic                    imem_gnt_i;
  logic                    imem_rvalid_i;
  logic [INST_W-1:0]       imem_rdata_i;
  logic                    redirect_i;
  logic [ADDR_W-1:0]       redirect_pc_i;
  logic                    id_valid_o;
  logic                    id_ready_i;
  logic [INST_W-1:0]       id_instr_o;
  logic [ADDR_W-1:0]       id_pc_o;
  logic [$clog2(DEPTH):0]  count_o;
  logic                    anomaly_o;
  modport master (
    output imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o, count_o, anomaly_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, id_ready_i
  );
  modport slave (
    input  imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o, count_o, anomaly_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, id_ready_i
  );
endinterface

// File: rtl/prefetch_unit.sv
// prefetch_unit: decoupled fetch stage, credit-limited imem requests, FWFT FIFO to ID, redirect drain; optional PREFETCH_BYPASS_EN
module prefetch_unit #(
  parameter int                ADDR_W          = 32,
  parameter int                INST_W          = 32,
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
  input logic             clk_i,
  input logic             rst_i,
  prefetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  typedef enum logic {FETCH, DRAIN} state_t;
  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        pc_q, resp_pc_q;
  logic [CW-1:0]            count_q, count_d, out_q, out_d, disc_q, disc_d;
  logic [AW-1:0]            wptr_q, rptr_q;
  logic [ADDR_W+INST_W-1:0] mem_q [DEPTH];
  logic [ADDR_W+INST_W-1:0] head;
  logic                     anomaly_q, grant, legit, accept, drop, push, pop, bypass, empty;
  assign empty = count_q == '0;
  assign head = mem_q[rptr_q];
  assign bus.imem_req_o = rst_i && !bus.redirect_i && out_q < CW'(MAX_OUTSTANDING)
                          && ({1'b0, count_q} + {1'b0, out_q}) < SW'(DEPTH);
  assign bus.imem_addr_o = pc_q;
  assign grant = bus.imem_req_o && bus.imem_gnt_i;
  assign legit = bus.imem_rvalid_i && out_q != '0;
  assign accept = legit && state_q == FETCH && !bus.redirect_i;
  assign drop = legit && state_q == DRAIN && !bus.redirect_i;
`ifdef PREFETCH_BYPASS_EN
  assign bypass = accept && empty;
`else
  assign bypass = 1'b0;
`endif
  assign pop = !empty && bus.id_ready_i;
  assign push = accept && !(bypass && bus.id_ready_i);
  assign bus.id_valid_o = !empty || bypass;
  assign bus.id_pc_o = !empty ? head[ADDR_W+INST_W-1:INST_W] : bypass ? resp_pc_q : '0;
  assign bus.id_instr_o = !empty ? head[INST_W-1:0] : bypass ? bus.imem_rdata_i : '0;
  assign bus.count_o = count_q;
  assign bus.anomaly_o = anomaly_q;
  // next-state: credits, occupancy, and the stale-response drain count that selects FETCH/DRAIN
  always_comb begin
    out_d = out_q + CW'(grant) - CW'(legit);
    count_d = bus.redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
    disc_d = bus.redirect_i ? out_d : drop ? disc_q - CW'(1) : disc_q;
    state_d = disc_d != '0 ? DRAIN : FETCH;
  end
  // state, pointers, fetch/response PCs and the sticky anomaly flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      count_q <= '0;
      out_q <= '0;
      disc_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      anomaly_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q <= out_d;
      disc_q <= disc_d;
      pc_q <= bus.redirect_i ? bus.redirect_pc_i : grant ? pc_q + ADDR_W'(4) : pc_q;
      resp_pc_q <= bus.redirect_i ? bus.redirect_pc_i : accept ? resp_pc_q + ADDR_W'(4) : resp_pc_q;
      wptr_q <= bus.redirect_i ? '0 : wptr_q + AW'(push);
      rptr_q <= bus.redirect_i ? '0 : rptr_q + AW'(pop);
      anomaly_q <= anomaly_q || (bus.redirect_i && bus.redirect_pc_i[1:0] != 2'b00)
                   || (bus.imem_rvalid_i && out_q == '0);
    end
  end
  // FIFO storage; a flushed FIFO simply rewinds its pointers
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= {resp_pc_q, bus.imem_rdata_i};
  end
endmodule

// File: doc/prefetch_unit.md
Name: prefetch_unit

Overview:
- Parametrised decoupled instruction fetch stage for the 5-stage core. It replaces the single-slot IF→IF_ID path.
- Issues sequential word fetches to instruction memory over a req/gnt + rvalid handshake, with up to MAX_OUTSTANDING in flight.
- Buffers returned {pc, instr} pairs in a DEPTH-entry FIFO and presents them first-word-fall-through to ID.
- On a branch-unit redirect it flushes the FIFO and discards stale in-flight responses.

Parameters:
- ADDR_W, 32, PC / memory address width.
- INST_W, 32, instruction width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests; 1..DEPTH.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  ADDR_W  fetch address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; responses return in order.
- imem_rdata_i  in  INST_W  response instruction.
- redirect_i  in  1  branch-unit PC write.
- redirect_pc_i  in  ADDR_W  new fetch PC.
- id_valid_o  out  1  head entry valid.
- id_ready_i  in  1  ID accepts head; low when the hazard unit stalls.
- id_instr_o  out  INST_W  head instruction.
- id_pc_o  out  ADDR_W  head PC.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- anomaly_o  out  1  sticky protocol/alignment error.

Behaviour:
- Reset (rst_i low, async): pc_q = RESET_PC, resp_pc = RESET_PC, FIFO empty. outstanding = 0, discard = 0, state = FETCH. All outputs 0 except imem_addr_o = RESET_PC.
- Issue: imem_req_o = !redirect_i && outstanding < MAX_OUTSTANDING && count + outstanding < DEPTH. imem_addr_o = pc_q.
  - While req is high without gnt, addr stays stable. Req may drop without gnt only in a redirect cycle.
- On req && gnt: pc_q += 4 (wraps modulo 2^ADDR_W); outstanding++.
- On rvalid: outstanding--.
  - In FETCH: push {resp_pc, rdata} and resp_pc += 4.
  - In DRAIN: drop the response, discard--. When discard reaches 0, go to FETCH.
- Output: id_valid_o = count != 0; id_instr_o/id_pc_o = head. Pop on id_valid_o && id_ready_i. Push and pop in the same cycle leave count unchanged. The credit rule guarantees no push ever hits a full FIFO.
- Redirect (highest priority), in the cycle redirect_i = 1:
  - Next edge: FIFO cleared (the same-cycle pop is irrelevant); pc_q = resp_pc = redirect_pc_i.
  - discard = outstanding + (req && gnt) − rvalid.
  - State = DRAIN if discard > 0, else FETCH.
  - The same-cycle rvalid is dropped; the same-cycle granted request is counted for discard.
- During DRAIN: new requests to the redirected PC may issue. A second redirect during DRAIN recomputes discard by the same formula.
- State machine:
  - FETCH → DRAIN on a redirect with discard > 0.
  - DRAIN → FETCH when discard hits 0 with no new redirect.
- anomaly_o: set on redirect with redirect_pc_i[1:0] != 0, or on rvalid with outstanding == 0. Cleared only by reset.
  - A misaligned PC is still loaded, with its low bits kept.
- Latency: response edge → id_valid_o next cycle (1 cycle); redirect → first new request the cycle after the redirect.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined: when the FIFO is empty, state is FETCH and rvalid arrives, id_valid_o/id_instr_o/id_pc_o are driven combinationally from the response in that cycle.
  - If id_ready_i is also high, the entry is consumed without being written (zero-cycle latency).
  - Otherwise it is pushed as normal.
- Undefined: responses are always written first; id_valid_o rises the following cycle.

Test Plan:
- Reset release, memory gnt=1 every cycle, rvalid 1 cycle after gnt, id_ready=1 → addresses 0x0,0x4,0x8…; id_pc_o sequence 0x0,0x4,0x8; outstanding never exceeds 2.
- id_ready_i=0 for 10 cycles with DEPTH=4 → count_o saturates at 4; imem_req_o low once count+outstanding=4; no lost or duplicated PCs after release.
- Two grants outstanding (0x8, 0xC), then redirect_pc_i=0x100 → both stale responses dropped; next id_pc_o = 0x100 with the correct instruction; count_o=0 the cycle after redirect.
- Redirect in the same cycle as gnt and rvalid → discard count correct; no stale entry reaches ID.
- redirect_pc_i=0x102, or rvalid with nothing outstanding → anomaly_o=1 and stays 1 until rst_i low.
- With PREFETCH_BYPASS_EN, empty FIFO, id_ready=1 → id_valid_o in the same cycle as rvalid; without it, one cycle later.
